// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash stand-in: decodes READ/FAST READ/JEDEC ID/STATUS/RELEASE-PD and serves bytes
// from a byte-wide memory port, with all SPI pins oversampled on MCLK.
module spi_flash_responder #(
  parameter int          ADDR_W      = 22,
  parameter int          SYNC_STAGES = 2,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016
) (
  input  logic              MCLK,
  input  logic              RST,
  input  logic              nCS,
  input  logic              CLK,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  output logic              RDREQ,
  output logic [ADDR_W-1:0] RDADDR,
  input  logic [7:0]        RDDATA,
  input  logic              RDVALID,
  output logic              BUSY,
  output logic              UNDERRUN
);
  localparam int SR_W = (ADDR_W - 1 > 7) ? ADDR_W - 1 : 7;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_ID, S_ID1, S_STAT, S_IGNORE
  } state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d, clk_sync_q, clk_sync_d, mosi_sync_q, mosi_sync_d;
  logic ncs_prev_q, ncs_prev_d, clk_prev_q, clk_prev_d;
  logic [4:0] cnt_q, cnt_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [7:0] op_q, op_d;
  logic [6:0] out_sr_q, out_sr_d;
  logic [2:0] out_cnt_q, out_cnt_d;
  logic [1:0] id_idx_q, id_idx_d;
  logic [7:0] hold_q, hold_d;
  logic hold_vld_q, hold_vld_d, pending_q, pending_d, skip_q, skip_d;
  logic miso_q, miso_d, oe_q, oe_d, rdreq_q, rdreq_d, underrun_q, underrun_d;
  logic [ADDR_W-1:0] rdaddr_q, rdaddr_d;

  logic ncs_s, clk_s, mosi_s, clk_rise, clk_fall, ncs_rise, ncs_fall;
  logic [7:0] cmd_v, byte_v;
  logic [ADDR_W-1:0] addr_v;

  assign ncs_s    = ncs_sync_q[SYNC_STAGES-1];
  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev_q;
  assign clk_fall = ~clk_s & clk_prev_q;
  assign ncs_rise = ncs_s & ~ncs_prev_q;
  assign ncs_fall = ~ncs_s & ncs_prev_q;
  assign cmd_v    = {sr_q[6:0], mosi_s};
  assign addr_v   = {sr_q[ADDR_W-2:0], mosi_s};

  always_comb begin
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], nCS};
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], CLK};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    ncs_prev_d  = ncs_s;
    clk_prev_d  = clk_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    op_d        = op_q;
    out_sr_d    = out_sr_q;
    out_cnt_d   = out_cnt_q;
    id_idx_d    = id_idx_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    pending_d   = pending_q;
    skip_d      = skip_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    rdreq_d     = 1'b0;
    rdaddr_d    = rdaddr_q;
    underrun_d  = underrun_q;
    byte_v      = 8'h00;

    // A response for a byte already declared underrun is dropped and the next fetch follows at once.
    if (RDVALID && pending_q) begin
      if (skip_q) begin
        skip_d   = 1'b0;
        rdreq_d  = 1'b1;
        rdaddr_d = rdaddr_q + 1'b1;
      end else begin
        hold_d     = RDDATA;
        hold_vld_d = 1'b1;
        pending_d  = 1'b0;
      end
    end

    if (ncs_rise) begin
      state_d    = S_IDLE;
      oe_d       = 1'b0;
      pending_d  = 1'b0;
      skip_d     = 1'b0;
      hold_vld_d = 1'b0;
      rdreq_d    = 1'b0;
      rdaddr_d   = rdaddr_q;
    end else begin
      case (state_q)
        S_IDLE: if (ncs_fall) begin
          state_d   = S_CMD;
          cnt_d     = 5'd0;
          out_cnt_d = 3'd0;
          id_idx_d  = 2'd0;
        end
        S_CMD: if (clk_rise) begin
          sr_d  = {sr_q[SR_W-2:0], mosi_s};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            op_d  = cmd_v;
            cnt_d = 5'd0;
            case (cmd_v)
              8'h03, 8'h0B, 8'hAB: state_d = S_ADDR;
              8'h9F:               state_d = S_ID;
              8'h05:               state_d = S_STAT;
              default:             state_d = S_IGNORE;
            endcase
          end
        end
        S_ADDR: if (clk_rise) begin
          sr_d  = {sr_q[SR_W-2:0], mosi_s};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            cnt_d = 5'd0;
            if (op_q == 8'hAB) begin
              state_d = S_ID1;
            end else begin
              state_d    = (op_q == 8'h0B) ? S_DUMMY : S_DATA;
              rdaddr_d   = addr_v;
              rdreq_d    = 1'b1;
              pending_d  = 1'b1;
              hold_vld_d = 1'b0;
              skip_d     = 1'b0;
            end
          end
        end
        S_DUMMY: if (clk_rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) state_d = S_DATA;
        end
        S_DATA, S_ID, S_ID1, S_STAT: if (clk_fall) begin
          oe_d      = 1'b1;
          out_cnt_d = out_cnt_q + 3'd1;
          if (out_cnt_q == 3'd0) begin
            if (state_q == S_DATA) begin
              if (hold_vld_q) begin
                byte_v     = hold_q;
                hold_vld_d = 1'b0;
                rdreq_d    = 1'b1;
                rdaddr_d   = rdaddr_q + 1'b1;
                pending_d  = 1'b1;
              end else begin
                underrun_d = 1'b1;
                if (RDVALID && pending_q && !skip_q) begin
                  hold_vld_d = 1'b0;
                  rdreq_d    = 1'b1;
                  rdaddr_d   = rdaddr_q + 1'b1;
                  pending_d  = 1'b1;
                end else begin
                  skip_d = 1'b1;
                end
              end
            end else if (state_q == S_ID) begin
              case (id_idx_q)
                2'd0:    byte_v = JEDEC_ID[23:16];
                2'd1:    byte_v = JEDEC_ID[15:8];
                default: byte_v = JEDEC_ID[7:0];
              endcase
              id_idx_d = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
            end else if (state_q == S_ID1) begin
              byte_v = JEDEC_ID[7:0];
            end
            miso_d   = byte_v[7];
            out_sr_d = byte_v[6:0];
          end else begin
            miso_d   = out_sr_q[6];
            out_sr_d = {out_sr_q[5:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge MCLK) begin
    if (RST) begin
      ncs_sync_q  <= '1;
      clk_sync_q  <= '0;
      mosi_sync_q <= '0;
      ncs_prev_q  <= 1'b1;
      clk_prev_q  <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      op_q        <= '0;
      out_sr_q    <= '0;
      out_cnt_q   <= '0;
      id_idx_q    <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      pending_q   <= 1'b0;
      skip_q      <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      rdreq_q     <= 1'b0;
      rdaddr_q    <= '0;
      underrun_q  <= 1'b0;
    end else begin
      ncs_sync_q  <= ncs_sync_d;
      clk_sync_q  <= clk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ncs_prev_q  <= ncs_prev_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      op_q        <= op_d;
      out_sr_q    <= out_sr_d;
      out_cnt_q   <= out_cnt_d;
      id_idx_q    <= id_idx_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      pending_q   <= pending_d;
      skip_q      <= skip_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      rdreq_q     <= rdreq_d;
      rdaddr_q    <= rdaddr_d;
      underrun_q  <= underrun_d;
    end
  end

  assign MISO     = miso_q;
  assign MISO_OE  = oe_q;
  assign RDREQ    = rdreq_q;
  assign RDADDR   = rdaddr_q;
  assign BUSY     = ~ncs_s;
  assign UNDERRUN = underrun_q;
endmodule
